xava_result_queue: RTL

XAVA_RESULT_QUEUE -- requirements
Module: xava_result_queue

---
 rtl/xava_result_queue.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/xava_result_queue.sv
// In-order result queue for X-IF offloaded instructions: tracks issue, commit/kill and
// accelerator completion per entry, and returns scalar results to the core in issue order.
module xava_result_queue #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_fire_i,
  input  logic [ID_W-1:0]            issue_id_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       issue_we_i,
  output logic                       alloc_ready_o,
  input  logic                       commit_valid_i,
  input  logic [ID_W-1:0]            commit_id_i,
  input  logic                       commit_kill_i,
  input  logic                       apu_rvalid_i,
  input  logic [31:0]                apu_result_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_W-1:0]            result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic [31:0]                result_data_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d, cmt_q, cmt_d, kill_q, kill_d, done_q, done_d, we_q, we_d;
  logic [ID_W-1:0]  id_q   [DEPTH];
  logic [ID_W-1:0]  id_d   [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             push, pop, drop, res_vld, cmt_hit, apu_hit;

  // Pushes see only the registered count, so a same-cycle pop never frees a slot early.
  assign alloc_ready_o = (count_q < DEPTH_C);
  assign push          = issue_fire_i & alloc_ready_o;
  assign res_vld       = valid_q[head_q] & cmt_q[head_q] & ~kill_q[head_q] & done_q[head_q];
  assign drop          = valid_q[head_q] & cmt_q[head_q] & kill_q[head_q];
  assign pop           = (res_vld & result_ready_i) | drop;

  always_comb begin
    valid_d = valid_q;
    cmt_d   = cmt_q;
    kill_d  = kill_q;
    done_d  = done_q;
    we_d    = we_q;
    id_d    = id_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    cmt_hit = 1'b0;
    apu_hit = 1'b0;
    idx     = '0;

    if (issue_fire_i && !alloc_ready_o) err_d = 1'b1;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      id_d[tail_q]    = issue_id_i;
      rd_d[tail_q]    = issue_rd_i;
      we_d[tail_q]    = issue_we_i;
      cmt_d[tail_q]   = 1'b0;
      kill_d[tail_q]  = 1'b0;
      done_d[tail_q]  = 1'b0;
      data_d[tail_q]  = '0;
      tail_d          = tail_q + PW'(1);
    end

    // Commit matches the oldest in-flight entry first, then the entry being allocated now.
    if (commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if (!cmt_hit && valid_q[idx] && !cmt_q[idx] && id_q[idx] == commit_id_i) begin
          cmt_d[idx]  = 1'b1;
          kill_d[idx] = commit_kill_i;
          cmt_hit     = 1'b1;
        end
      end
      if (!cmt_hit && push && issue_id_i == commit_id_i) begin
        cmt_d[tail_q]  = 1'b1;
        kill_d[tail_q] = commit_kill_i;
        cmt_hit        = 1'b1;
      end
      if (!cmt_hit) err_d = 1'b1;
    end

    if (apu_rvalid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if (!apu_hit && valid_q[idx] && !done_q[idx] && !kill_q[idx]) begin
          done_d[idx] = 1'b1;
          data_d[idx] = apu_result_i;
          apu_hit     = 1'b1;
        end
      end
      if (!apu_hit) err_d = 1'b1;
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      cmt_q   <= '0;
      kill_q  <= '0;
      done_q  <= '0;
      we_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cmt_q   <= cmt_d;
      kill_q  <= kill_d;
      done_q  <= done_d;
      we_q    <= we_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Packet fields are zeroed whenever no result is offered.
  assign result_valid_o = res_vld;
  assign result_id_o    = res_vld ? id_q[head_q] : '0;
  assign result_rd_o    = res_vld ? rd_q[head_q] : '0;
  assign result_we_o    = res_vld & we_q[head_q];
  assign result_data_o  = (res_vld && we_q[head_q]) ? data_q[head_q] : '0;
  assign count_o        = count_q;
  assign err_o          = err_q;

endmodule
